// File: rtl/tetris_input_scheduler_if.sv
// rtl/tetris_input_scheduler_if.sv - command valid/ready channel toward the game-logic FSM
interface tetris_input_scheduler_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_code;

  modport master (output cmd_valid, output cmd_code, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_code, output cmd_ready);
endinterface

// File: rtl/tetris_input_scheduler.sv
// rtl/tetris_input_scheduler.sv - button edge/DAS/ARR event generation with priority command output
module tetris_input_scheduler #(
  parameter int CNT_W      = 25,
  parameter int DAS_DELAY  = 8000,
  parameter int ARR_PERIOD = 2500
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic btn_left,
  input  logic btn_right,
  input  logic btn_rotate,
  input  logic btn_down,
  input  logic btn_drop,
  tetris_input_scheduler_if.master cmd
);
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_t;

  localparam logic [CNT_W-1:0] DAS_LAST = CNT_W'(DAS_DELAY - 1);
  localparam logic [CNT_W-1:0] ARR_LAST = CNT_W'(ARR_PERIOD - 1);

  logic             clear;
  logic             conflict;
  logic [2:0]       rep_level;
  logic [2:0]       rep_prev;
  logic [2:0]       rep_event;
  rep_state_t       state_q [3];
  rep_state_t       state_d [3];
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];
  logic             rot_prev;
  logic             drop_prev;
  logic [4:0]       ev;
  logic [4:0]       pend;
  logic [4:0]       grant_mask;
  logic [2:0]       sel_code;
  logic             free;
  logic             valid_q;
  logic [2:0]       code_q;

  assign clear    = reset | ~enable;
  assign conflict = btn_left & btn_right;
  // Masking both laterals during a conflict makes the survivor look like a fresh press on release.
  assign rep_level = {btn_down, btn_right & ~conflict, btn_left & ~conflict};

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      state_d[i]   = state_q[i];
      cnt_d[i]     = cnt_q[i];
      rep_event[i] = 1'b0;
      if (!rep_level[i]) begin
        state_d[i] = IDLE;
        cnt_d[i]   = '0;
      end else begin
        case (state_q[i])
          IDLE: if (!rep_prev[i]) begin
            rep_event[i] = 1'b1;
            cnt_d[i]     = '0;
            state_d[i]   = DELAY;
          end
          DELAY: if (cnt_q[i] == DAS_LAST) begin
            rep_event[i] = 1'b1;
            cnt_d[i]     = '0;
            state_d[i]   = REPEAT;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
          REPEAT: if (cnt_q[i] == ARR_LAST) begin
            rep_event[i] = 1'b1;
            cnt_d[i]     = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
          default: begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end
        endcase
      end
    end
  end

  // Bit n-1 of ev/pend holds command code n.
  assign ev = {btn_drop & ~drop_prev, rep_event[2], btn_rotate & ~rot_prev,
               rep_event[1], rep_event[0]};

  always_comb begin
    sel_code   = 3'd0;
    grant_mask = 5'b00000;
    if (pend[4]) begin
      sel_code = 3'd5; grant_mask = 5'b10000;
    end else if (pend[2]) begin
      sel_code = 3'd3; grant_mask = 5'b00100;
    end else if (pend[0]) begin
      sel_code = 3'd1; grant_mask = 5'b00001;
    end else if (pend[1]) begin
      sel_code = 3'd2; grant_mask = 5'b00010;
    end else if (pend[3]) begin
      sel_code = 3'd4; grant_mask = 5'b01000;
    end
  end

  assign free = ~valid_q | cmd.cmd_ready;

  always_ff @(posedge clk) begin
    if (clear) begin
      valid_q   <= 1'b0;
      code_q    <= 3'd0;
      pend      <= 5'b00000;
      rot_prev  <= 1'b0;
      drop_prev <= 1'b0;
      rep_prev  <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      rot_prev  <= btn_rotate;
      drop_prev <= btn_drop;
      rep_prev  <= rep_level;
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      if (free) begin
        valid_q <= |pend;
        code_q  <= sel_code;
      end
      // A same-cycle event re-arms the bit being granted.
      pend <= (pend & ~(free ? grant_mask : 5'b00000)) | ev;
    end
  end

  assign cmd.cmd_valid = valid_q;
  assign cmd.cmd_code  = code_q;
endmodule

// File: tb/tb_tetris_input_scheduler.sv
// tb/tb_tetris_input_scheduler.sv - directed and random checks against a hold-age reference model
module tb_tetris_input_scheduler;
  localparam int DAS = 4;
  localparam int ARR = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b1;
  logic btn_left = 1'b0;
  logic btn_right = 1'b0;
  logic btn_rotate = 1'b0;
  logic btn_down = 1'b0;
  logic btn_drop = 1'b0;

  int pass_cnt = 0;
  int total_cnt = 0;
  bit started = 1'b0;

  tetris_input_scheduler_if cmd_if ();

  tetris_input_scheduler #(.CNT_W(8), .DAS_DELAY(DAS), .ARR_PERIOD(ARR)) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .btn_left(btn_left),
    .btn_right(btn_right),
    .btn_rotate(btn_rotate),
    .btn_down(btn_down),
    .btn_drop(btn_drop),
    .cmd(cmd_if)
  );

  always #5 clk = ~clk;

  // Reference model: each repeatable button tracks how long it has been effectively held.
  int       age [3];
  bit       prev_rot, prev_drop;
  bit [5:1] pend;
  bit       m_valid;
  bit [2:0] m_code;
  int       prio [5] = '{5, 3, 1, 2, 4};
  int       code_of [3] = '{1, 2, 4};

  function automatic bit fires(input int a);
    return (a == 0) || (a == DAS) || (a > DAS && ((a - DAS) % ARR) == 0);
  endfunction

  task automatic model_step();
    bit       lv [3];
    bit [5:1] evm;
    if (reset || !enable) begin
      for (int i = 0; i < 3; i++) age[i] = -1;
      prev_rot = 0; prev_drop = 0; pend = '0; m_valid = 0; m_code = 0;
      return;
    end
    lv[0] = btn_left && !btn_right;
    lv[1] = btn_right && !btn_left;
    lv[2] = btn_down;
    evm = '0;
    for (int i = 0; i < 3; i++) begin
      if (lv[i]) begin
        age[i] = (age[i] < 0) ? 0 : age[i] + 1;
        if (fires(age[i])) evm[code_of[i]] = 1'b1;
      end else begin
        age[i] = -1;
      end
    end
    evm[3] = btn_rotate && !prev_rot;
    evm[5] = btn_drop && !prev_drop;
    prev_rot = btn_rotate;
    prev_drop = btn_drop;
    if (!m_valid || cmd_if.cmd_ready) begin
      m_valid = 0;
      m_code = 0;
      for (int p = 0; p < 5; p++) begin
        if (pend[prio[p]]) begin
          m_valid = 1;
          m_code = 3'(prio[p]);
          pend[prio[p]] = 1'b0;
          break;
        end
      end
    end
    pend = pend | evm;
  endtask

  always @(posedge clk) model_step();

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else
      pass_cnt++;
  endtask

  always @(negedge clk) begin
    if (started) begin
      check("model_valid", 32'(cmd_if.cmd_valid), 32'(m_valid));
      check("model_code", 32'(cmd_if.cmd_code), 32'(m_code));
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    btn_left = 0; btn_right = 0; btn_rotate = 0; btn_down = 0; btn_drop = 0;
    enable = 1; reset = 1;
    step();
    reset = 0;
  endtask

  function automatic bit is_code(input int c);
    return cmd_if.cmd_valid === 1'b1 && cmd_if.cmd_code === 3'(c);
  endfunction

  initial begin
    int          n;
    logic [31:0] lmask, rmask;
    int          exp_pr [8] = '{0, 5, 5, 5, 5, 3, 4, 0};

    cmd_if.cmd_ready = 1;
    do_reset();
    started = 1;
    check("reset_valid", 32'(cmd_if.cmd_valid), 0);
    check("reset_code", 32'(cmd_if.cmd_code), 0);

    // Tap: rotate for one cycle at cycle 10
    do_reset();
    repeat (10) step();
    btn_rotate = 1; step();
    btn_rotate = 0; step();
    check("tap_valid", 32'(cmd_if.cmd_valid), 1);
    check("tap_code", 32'(cmd_if.cmd_code), 3);
    step();
    check("tap_one_cycle", 32'(cmd_if.cmd_valid), 0);

    btn_rotate = 1; n = 0;
    repeat (50) begin step(); if (is_code(3)) n++; end
    btn_rotate = 0;
    repeat (3) begin step(); if (is_code(3)) n++; end
    check("rotate_hold_count", 32'(n), 1);

    // Auto-repeat: left held cycles 0..18
    do_reset();
    lmask = '0;
    for (int j = 1; j <= 26; j++) begin
      btn_left = (j - 1 <= 18);
      step();
      if (is_code(1)) lmask[j] = 1'b1;
    end
    btn_left = 0;
    check("autorepeat_grants", lmask, 32'h0015_5544);

    // Priority and stall
    do_reset();
    for (int j = 1; j <= 8; j++) begin
      cmd_if.cmd_ready = (j - 1 >= 5);
      btn_drop = (j == 1); btn_rotate = (j == 1); btn_down = (j == 1);
      step();
      check($sformatf("priority_step%0d", j),
            cmd_if.cmd_valid === 1'b1 ? 32'(cmd_if.cmd_code) : 32'd0, 32'(exp_pr[j-1]));
    end
    btn_drop = 0; btn_rotate = 0; btn_down = 0; cmd_if.cmd_ready = 1;

    // Lateral conflict
    do_reset();
    lmask = '0; rmask = '0;
    for (int j = 1; j <= 24; j++) begin
      btn_left = (j - 1 < 15);
      btn_right = (j - 1 >= 5);
      step();
      if (is_code(1)) lmask[j] = 1'b1;
      if (is_code(2)) rmask[j] = 1'b1;
    end
    btn_left = 0; btn_right = 0;
    check("lateral_left", lmask, 32'h0000_0044);
    check("lateral_right", rmask, 32'h00A2_0000);

    // Coalescing under stall
    do_reset();
    n = 0;
    for (int j = 1; j <= 23; j++) begin
      cmd_if.cmd_ready = (j - 1 >= 20);
      btn_down = (j - 1 <= 18);
      step();
      if (is_code(4)) n++;
      if (j == 21) check("coalesce_second", 32'(is_code(4)), 1);
      if (j == 22) check("coalesce_no_burst", 32'(cmd_if.cmd_valid), 0);
    end
    btn_down = 0; cmd_if.cmd_ready = 1;
    check("coalesce_valid_cycles", 32'(n), 20);

    // Reset mid-stream
    do_reset();
    btn_left = 1; step(); step();
    check("pre_reset_code", 32'(is_code(1)), 1);
    reset = 1; btn_left = 0; step();
    reset = 0;
    check("post_reset_valid", 32'(cmd_if.cmd_valid), 0);
    check("post_reset_code", 32'(cmd_if.cmd_code), 0);
    n = 0;
    repeat (5) begin step(); if (is_code(1)) n++; end
    check("no_left_after_reset", 32'(n), 0);
    btn_left = 1; step(); step();
    check("fresh_rise_left", 32'(is_code(1)), 1);
    btn_left = 0;

    // enable low drops cmd_valid mid-handshake
    do_reset();
    cmd_if.cmd_ready = 0; btn_left = 1; step(); step();
    check("abort_pre_valid", 32'(cmd_if.cmd_valid), 1);
    enable = 0; step();
    check("abort_drops_valid", 32'(cmd_if.cmd_valid), 0);
    enable = 1; btn_left = 0; cmd_if.cmd_ready = 1; step();

    // Random traffic
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 99) < 8) btn_left = ~btn_left;
      if ($urandom_range(0, 99) < 8) btn_right = ~btn_right;
      if ($urandom_range(0, 99) < 8) btn_rotate = ~btn_rotate;
      if ($urandom_range(0, 99) < 8) btn_down = ~btn_down;
      if ($urandom_range(0, 99) < 8) btn_drop = ~btn_drop;
      cmd_if.cmd_ready = ($urandom_range(0, 99) < 70);
      reset = ($urandom_range(0, 199) == 0);
      enable = ($urandom_range(0, 199) != 0);
      step();
    end
    reset = 0; enable = 1;
    step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/tetris_input_scheduler.md
Name: tetris_input_scheduler

Overview:
- Sits between the per-button debounce stages and the Tetris game-logic FSM.
- Turns five debounced button levels into a single stream of move commands.
- Applies edge detection and delayed auto-shift/auto-repeat to left, right and down.
- Arbitrates simultaneous requests by fixed priority and delivers one command at a time over a valid/ready handshake.

Parameters:
- CNT_W, 25, width of the hold-time counters.
- DAS_DELAY, 8000, clk cycles a repeatable button must stay held after its first event before the first repeat (≥1).
- ARR_PERIOD, 2500, clk cycles between subsequent repeats (≥1).

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  synchronous, active-high; clears all state.
- enable  input  1  game active; low acts as a synchronous abort.
- btn_left  input  1  debounced level.
- btn_right  input  1  debounced level.
- btn_rotate  input  1  debounced level.
- btn_down  input  1  debounced level.
- btn_drop  input  1  debounced level.
- cmd_ready  input  1  game logic accepts the command this cycle.
- cmd_valid  output  1  command present (registered).
- cmd_code  output  3  1=LEFT 2=RIGHT 3=ROTATE 4=DOWN 5=DROP, 0 when idle (registered).

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (`reset`).
- Reset values: cmd_valid=0, cmd_code=0, all pending bits=0, all counters=0, all button FSMs=IDLE, previous-level registers=0.
- enable=0 has the same effect as reset, including dropping cmd_valid mid-handshake. This is the only case in which cmd_valid may fall without a grant.
- Edge detect: event on a 0→1 transition of the registered previous level.
- Rotate and drop issue exactly one event per press and never repeat.
- Repeatable buttons (left, right, down) each run an FSM:
  - IDLE → on rise: event, cnt=0, go to DELAY.
  - DELAY → cnt++ each held cycle; when cnt==DAS_DELAY-1: event, cnt=0, go to REPEAT.
  - REPEAT → cnt++; when cnt==ARR_PERIOD-1: event, cnt=0, stay in REPEAT.
  - Any state → on release (level 0): IDLE, cnt=0, same cycle.
- Counter width: counters never exceed their target and do not wrap.
- Lateral conflict: while btn_left and btn_right are both 1, both lateral FSMs are forced to IDLE and generate no events. When one is released, the other behaves as newly pressed and emits an event on the next cycle.
- Pending: each event sets that button's pending bit.
  - An event for an already-pending button is coalesced; it does not queue twice.
  - Releasing a button does not clear its pending bit, so a one-cycle tap is still delivered.
- Output stage updates when cmd_valid==0 or cmd_ready==1:
  - If any bit is pending: cmd_valid←1, cmd_code←highest-priority pending (DROP > ROTATE > LEFT > RIGHT > DOWN), and that bit is cleared.
  - If nothing is pending: cmd_valid←0, cmd_code←0.
- Stall: while cmd_valid=1 and cmd_ready=0, cmd_valid and cmd_code hold stable.
- Latency: button rise at cycle N sets pending at N+1. cmd_valid is asserted at N+2 if the output stage is free. Back-to-back grants are possible with cmd_ready held at 1.
- Simultaneous grant and new event for the same button in one cycle: the pending bit ends at 1, because the new event is a distinct request.
- cmd_ready while cmd_valid=0 is ignored.

Test Plan (DAS_DELAY=4, ARR_PERIOD=2, cmd_ready=1 unless stated):
- Reset mid-stream: hold btn_left with cmd_valid=1, assert reset for 1 cycle. Next cycle cmd_valid=0 and cmd_code=0; no LEFT until a fresh rise after reset.
- Tap: btn_rotate high for 1 cycle at cycle 10. cmd_valid=1 with code 3 at cycle 12 for exactly 1 cycle. Holding btn_rotate 50 cycles gives still exactly one code 3.
- Auto-repeat: btn_left held from cycle 0 to cycle 20. LEFT grants at cycles 2, 6, 8, 10, …, 20 (first, then DAS, then every 2). No grants after release.
- Priority and stall: btn_drop, btn_rotate and btn_down rise together with cmd_ready=0 for 5 cycles. code 5 is held stable during the stall; after cmd_ready=1, grants follow as 5, 3, 4 on consecutive cycles.
- Lateral conflict: left held, right pressed at cycle 5. No LEFT or RIGHT events while both are held. Release left at cycle 15 → RIGHT granted at cycle 17, then repeats per DAS/ARR.
- Coalescing: btn_down repeating with cmd_ready=0 for 20 cycles. Only one DOWN is delivered when ready returns; no backlog burst.
